// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder: FSM state, byte type and
// the default filler byte sent when nothing is queued for transmit.
package spi_pkg;

    typedef logic [7:0] spi_byte_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    localparam spi_byte_t IDLE_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync.sv
// Single-bit synchronizer of configurable depth with a configurable reset level,
// so each SPI input can come out of reset at its idle value.
module spi_sync #(
    parameter int   STAGES      = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RESET_VALUE}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder clocked from the system clock: oversamples cs/sclk/mosi,
// shifts bytes in and out, and holds a one-entry transmit buffer.
module spi_responder
    import spi_pkg::*;
#(
    parameter int        SYNC_STAGES = 2,
    parameter spi_byte_t IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output spi_byte_t  rx_data,
    output logic       rx_valid,
    input  spi_byte_t  tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_underrun,
    output spi_state_t fsm_state
);

    logic cs_s, sclk_s, mosi_s;
    logic cs_d, sclk_d;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(spi_cs), .q(cs_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s)
    );

    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    assign cs_fall   =  cs_d   & ~cs_s;
    assign cs_rise   = ~cs_d   &  cs_s;
    assign sclk_rise = ~sclk_d &  sclk_s;
    assign sclk_fall =  sclk_d & ~sclk_s;

    spi_state_t state_q, state_n;
    logic [2:0] bit_cnt;
    spi_byte_t  rx_shift, rx_next, tx_shift, buf_data;
    logic       buf_full;
    logic       load, accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:   if (cs_fall) state_n = ST_ACTIVE;
            ST_ACTIVE: if (cs_rise) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // Shifter loads at selection and at every byte boundary; a deselect wins over an edge.
    assign load    = ((state_q == ST_IDLE) && cs_fall) ||
                     ((state_q == ST_ACTIVE) && !cs_rise && sclk_fall && (bit_cnt == 3'd0));
    assign accept  = tx_valid && !buf_full;
    assign rx_next = {rx_shift[6:0], mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_d        <= 1'b1;
            sclk_d      <= 1'b0;
            bit_cnt     <= 3'd0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_shift    <= IDLE_BYTE;
            buf_data    <= '0;
            buf_full    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            cs_d        <= cs_s;
            sclk_d      <= sclk_s;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;

            // An empty buffer at load time sends the filler even if a byte arrives now.
            if (load) begin
                if (buf_full) begin
                    tx_shift <= buf_data;
                end else begin
                    tx_shift    <= IDLE_BYTE;
                    tx_underrun <= 1'b1;
                end
            end

            if (accept) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
            end else if (load && buf_full) begin
                buf_full <= 1'b0;
            end

            if (state_q == ST_IDLE) begin
                if (cs_fall) begin
                    bit_cnt  <= 3'd0;
                    rx_shift <= '0;
                end
            end else if (cs_rise) begin
                bit_cnt  <= 3'd0;
                rx_shift <= '0;
                tx_shift <= IDLE_BYTE;
            end else if (sclk_rise) begin
                rx_shift <= rx_next;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
            end else if (sclk_fall && (bit_cnt != 3'd0)) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    assign spi_miso    = (state_q == ST_ACTIVE) ? tx_shift[7] : 1'b1;
    assign spi_miso_oe = (state_q == ST_ACTIVE);
    assign tx_ready    = !buf_full;
    assign fsm_state   = state_q;

endmodule
